// File: rtl/qu_common.sv
// Shared queue/reservation-station types.
// Slot entry layout and depth used by RS schedulers.
package qu_common;

  localparam int RS_DEPTH     = 8;
  localparam int RS_TAG_WIDTH = $clog2(RS_DEPTH);

  typedef logic [RS_TAG_WIDTH-1:0] res_st_addr_t;

  typedef struct packed {
    logic         busy;
    logic         qj_pend;
    res_st_addr_t qj_tag;
    logic         qk_pend;
    res_st_addr_t qk_tag;
  } rs_sched_entry_t;

endpackage

// File: rtl/res_st_scheduler_if.sv
// Rename-alloc, CDB wakeup and FU-issue bundle
// between the pipeline and one RS scheduler.
interface res_st_scheduler_if
  import qu_common::*;
#(
  parameter int TAG_WIDTH = RS_TAG_WIDTH
);
  logic                 alloc_req_in;
  logic                 alloc_ok_out;
  logic [TAG_WIDTH-1:0] alloc_addr_out;
  logic                 alloc_qj_valid_in;
  logic [TAG_WIDTH-1:0] alloc_qj_in;
  logic                 alloc_qk_valid_in;
  logic [TAG_WIDTH-1:0] alloc_qk_in;
  logic                 cdb_valid_in;
  logic [TAG_WIDTH-1:0] cdb_tag_in;
  logic                 issue_valid_out;
  logic                 issue_ready_in;
  logic [TAG_WIDTH-1:0] issue_addr_out;

  modport master (
    output alloc_req_in, alloc_qj_valid_in, alloc_qj_in,
    output alloc_qk_valid_in, alloc_qk_in,
    output cdb_valid_in, cdb_tag_in, issue_ready_in,
    input  alloc_ok_out, alloc_addr_out,
    input  issue_valid_out, issue_addr_out
  );

  modport slave (
    input  alloc_req_in, alloc_qj_valid_in, alloc_qj_in,
    input  alloc_qk_valid_in, alloc_qk_in,
    input  cdb_valid_in, cdb_tag_in, issue_ready_in,
    output alloc_ok_out, alloc_addr_out,
    output issue_valid_out, issue_addr_out
  );

endinterface

// File: rtl/res_st_scheduler_rr_picker.sv
// Round-robin first-set finder: scans req_in upward
// from start_in, wrapping modulo N (N a power of two).
module rr_picker #(
  parameter int N         = 8,
  parameter int TAG_WIDTH = $clog2(N)
) (
  input  logic [N-1:0]         req_in,
  input  logic [TAG_WIDTH-1:0] start_in,
  output logic                 valid_out,
  output logic [TAG_WIDTH-1:0] idx_out
);

  always_comb begin
    valid_out = 1'b0;
    idx_out   = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid_out && req_in[start_in + TAG_WIDTH'(i)]) begin
        valid_out = 1'b1;
        idx_out   = start_in + TAG_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/res_st_scheduler.sv
// Reservation-station slot allocator, CDB wakeup
// tracker and round-robin issue selector.
module res_st_scheduler
  import qu_common::*;
#(
  parameter int RS_DEPTH  = qu_common::RS_DEPTH,
  parameter int TAG_WIDTH = $clog2(RS_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  res_st_scheduler_if.slave    bus,
  input  logic                 flush_in,
  output logic                 full_out,
  output logic                 empty_out,
  output logic [TAG_WIDTH:0]   count_out
);

  typedef logic [TAG_WIDTH:0]   cnt_t;
  typedef logic [TAG_WIDTH-1:0] idx_t;

  rs_sched_entry_t ent_q [RS_DEPTH];
  rs_sched_entry_t ent_d [RS_DEPTH];
  idx_t rr_ptr_q, rr_ptr_d;
  idx_t lock_addr_q, lock_addr_d;
  logic lock_q, lock_d;
  cnt_t count_q, count_d;

  logic [RS_DEPTH-1:0] ready;
  logic pick_valid;
  idx_t pick_idx;
  idx_t free_addr;
  idx_t issue_addr;
  logic alloc_ok;
  logic fire;
  logic qj_pend_new;
  logic qk_pend_new;

  always_comb begin
    ready = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready[i] = ent_q[i].busy & ~ent_q[i].qj_pend
               & ~ent_q[i].qk_pend;
    end
  end

  rr_picker #(
    .N        (RS_DEPTH),
    .TAG_WIDTH(TAG_WIDTH)
  ) u_pick (
    .req_in   (ready),
    .start_in (rr_ptr_q),
    .valid_out(pick_valid),
    .idx_out  (pick_idx)
  );

  always_comb begin
    free_addr = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) free_addr = idx_t'(i);
    end
  end

  assign full_out   = (count_q == cnt_t'(RS_DEPTH));
  assign empty_out  = (count_q == '0);
  assign count_out  = count_q;
  assign alloc_ok   = bus.alloc_req_in & ~full_out;
  assign issue_addr = lock_q ? lock_addr_q : pick_idx;
  assign fire       = pick_valid & bus.issue_ready_in;

  assign bus.alloc_ok_out    = alloc_ok;
  assign bus.alloc_addr_out  = free_addr;
  assign bus.issue_valid_out = pick_valid;
  assign bus.issue_addr_out  = issue_addr;

  // Same-cycle CDB hit on an incoming operand means it never waits.
  assign qj_pend_new = bus.alloc_qj_valid_in
    & ~(bus.cdb_valid_in & (bus.cdb_tag_in == bus.alloc_qj_in));
  assign qk_pend_new = bus.alloc_qk_valid_in
    & ~(bus.cdb_valid_in & (bus.cdb_tag_in == bus.alloc_qk_in));

  always_comb begin
    ent_d       = ent_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    lock_addr_d = lock_addr_q;
    count_d     = count_q + cnt_t'(alloc_ok) - cnt_t'(fire);
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (bus.cdb_valid_in && ent_q[i].busy) begin
        if (ent_q[i].qj_tag == bus.cdb_tag_in) ent_d[i].qj_pend = 1'b0;
        if (ent_q[i].qk_tag == bus.cdb_tag_in) ent_d[i].qk_pend = 1'b0;
      end
    end
    if (fire) begin
      ent_d[issue_addr].busy = 1'b0;
      rr_ptr_d = issue_addr + idx_t'(1);
      lock_d   = 1'b0;
    end else if (pick_valid) begin
      lock_d      = 1'b1;
      lock_addr_d = issue_addr;
    end
    if (alloc_ok) begin
      ent_d[free_addr].busy    = 1'b1;
      ent_d[free_addr].qj_pend = qj_pend_new;
      ent_d[free_addr].qj_tag  = bus.alloc_qj_in;
      ent_d[free_addr].qk_pend = qk_pend_new;
      ent_d[free_addr].qk_tag  = bus.alloc_qk_in;
    end
    if (flush_in) begin
      ent_d       = '{default: '0};
      rr_ptr_d    = '0;
      lock_d      = 1'b0;
      lock_addr_d = '0;
      count_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q       <= '{default: '0};
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_addr_q <= '0;
      count_q     <= '0;
    end else begin
      ent_q       <= ent_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_addr_q <= lock_addr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_res_st_scheduler.sv
// Directed bench for res_st_scheduler: alloc order,
// wakeup, bypass, backpressure lock, full and flush.
module tb_res_st_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_in;
  logic       full_out;
  logic       empty_out;
  logic [3:0] count_out;
  int         checks = 0;
  int         failures = 0;

  res_st_scheduler_if #(.TAG_WIDTH(3)) bus();

  res_st_scheduler #(
    .RS_DEPTH (8),
    .TAG_WIDTH(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush_in (flush_in),
    .full_out (full_out),
    .empty_out(empty_out),
    .count_out(count_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.alloc_req_in      = 1'b0;
    bus.alloc_qj_valid_in = 1'b0;
    bus.alloc_qj_in       = '0;
    bus.alloc_qk_valid_in = 1'b0;
    bus.alloc_qk_in       = '0;
    bus.cdb_valid_in      = 1'b0;
    bus.cdb_tag_in        = '0;
    flush_in              = 1'b0;
  endtask

  task automatic alloc(input bit jv, input logic [2:0] j,
                       input bit kv, input logic [2:0] k);
    bus.alloc_req_in      = 1'b1;
    bus.alloc_qj_valid_in = jv;
    bus.alloc_qj_in       = j;
    bus.alloc_qk_valid_in = kv;
    bus.alloc_qk_in       = k;
  endtask

  task automatic cdb(input logic [2:0] t);
    bus.cdb_valid_in = 1'b1;
    bus.cdb_tag_in   = t;
  endtask

  initial begin
    rst = 1'b1;
    bus.issue_ready_in = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_ok", bus.alloc_ok_out, 0);
    chk("rst_aaddr", bus.alloc_addr_out, 0);
    chk("rst_ivalid", bus.issue_valid_out, 0);
    chk("rst_iaddr", bus.issue_addr_out, 0);
    chk("rst_full", full_out, 0);
    chk("rst_empty", empty_out, 1);
    chk("rst_count", count_out, 0);

    // fill all eight slots, FU stalled
    for (int k = 0; k < 8; k++) begin
      alloc(0, 0, 0, 0);
      #1;
      chk("fill_addr", bus.alloc_addr_out, k);
      chk("fill_ok", bus.alloc_ok_out, 1);
      step();
    end
    #1;
    chk("fill_full", full_out, 1);
    chk("fill_count", count_out, 8);
    chk("fill_aaddr", bus.alloc_addr_out, 0);
    bus.alloc_req_in = 1'b1;
    #1;
    chk("fill_ok_blk", bus.alloc_ok_out, 0);
    bus.alloc_req_in = 1'b0;
    bus.issue_ready_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("drain_valid", bus.issue_valid_out, 1);
      chk("drain_addr", bus.issue_addr_out, k);
      step();
    end
    #1;
    chk("drain_empty", empty_out, 1);
    chk("drain_count", count_out, 0);
    chk("drain_valid0", bus.issue_valid_out, 0);

    // qj waits on tag 5, broadcast two cycles later
    alloc(1, 5, 0, 0);
    #1;
    chk("wk_aaddr", bus.alloc_addr_out, 0);
    step();
    #1;
    chk("wk_wait1", bus.issue_valid_out, 0);
    step();
    cdb(5);
    #1;
    chk("wk_wait2", bus.issue_valid_out, 0);
    step();
    #1;
    chk("wk_valid", bus.issue_valid_out, 1);
    chk("wk_addr", bus.issue_addr_out, 0);
    step();
    #1;
    chk("wk_empty", empty_out, 1);

    // qk hit by the CDB in the allocation cycle
    alloc(0, 0, 1, 3);
    cdb(3);
    #1;
    chk("byp_v0", bus.issue_valid_out, 0);
    step();
    #1;
    chk("byp_valid", bus.issue_valid_out, 1);
    chk("byp_addr", bus.issue_addr_out, 0);
    step();
    #1;
    chk("byp_empty", empty_out, 1);

    // backpressure: rr_ptr to 3, slots 2/6 ready, 4 wakes mid-stall
    bus.issue_ready_in = 1'b0;
    alloc(1, 7, 0, 0);
    step();
    alloc(1, 7, 0, 0);
    step();
    alloc(0, 0, 0, 0);
    step();
    bus.issue_ready_in = 1'b1;
    #1;
    chk("bp_pre_addr", bus.issue_addr_out, 2);
    step();
    bus.issue_ready_in = 1'b0;
    alloc(1, 5, 0, 0);
    #1;
    chk("bp_realloc", bus.alloc_addr_out, 2);
    step();
    alloc(1, 7, 0, 0);
    step();
    alloc(0, 0, 1, 6);
    step();
    alloc(1, 7, 0, 0);
    step();
    alloc(1, 5, 0, 0);
    #1;
    chk("bp_a6", bus.alloc_addr_out, 6);
    step();
    cdb(5);
    #1;
    chk("bp_none", bus.issue_valid_out, 0);
    step();
    cdb(6);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_hold_v", bus.issue_valid_out, 1);
      chk("bp_hold_a", bus.issue_addr_out, 6);
      step();
    end
    bus.issue_ready_in = 1'b1;
    #1;
    chk("bp_acc6", bus.issue_addr_out, 6);
    step();
    #1;
    chk("bp_wrap2", bus.issue_addr_out, 2);
    step();
    #1;
    chk("bp_next4", bus.issue_addr_out, 4);
    step();
    bus.issue_ready_in = 1'b0;
    #1;
    chk("bp_idle", bus.issue_valid_out, 0);
    chk("bp_count", count_out, 4);

    // flush beats alloc, wakeup and handshake
    alloc(0, 0, 0, 0);
    #1;
    chk("fl_a2", bus.alloc_addr_out, 2);
    step();
    flush_in = 1'b1;
    alloc(0, 0, 0, 0);
    cdb(7);
    bus.issue_ready_in = 1'b1;
    #1;
    chk("fl_cnt5", count_out, 5);
    chk("fl_offer", bus.issue_addr_out, 2);
    step();
    bus.issue_ready_in = 1'b0;
    #1;
    chk("fl_count", count_out, 0);
    chk("fl_empty", empty_out, 1);
    chk("fl_valid", bus.issue_valid_out, 0);

    // rr_ptr must be 0: slots 0 and 3 wake together
    alloc(1, 1, 0, 0);
    #1;
    chk("fl_a0", bus.alloc_addr_out, 0);
    step();
    alloc(1, 2, 0, 0);
    step();
    alloc(1, 2, 0, 0);
    step();
    alloc(1, 1, 0, 0);
    #1;
    chk("fl_a3", bus.alloc_addr_out, 3);
    step();
    alloc(1, 2, 0, 0);
    cdb(1);
    step();
    alloc(1, 2, 0, 0);
    #1;
    chk("fl_rr_v", bus.issue_valid_out, 1);
    chk("fl_rr0", bus.issue_addr_out, 0);
    step();
    alloc(1, 2, 0, 0);
    step();
    alloc(1, 2, 0, 0);
    #1;
    chk("fl_a7", bus.alloc_addr_out, 7);
    step();

    // full: issue and alloc request in the same cycle
    #1;
    chk("fu_full", full_out, 1);
    chk("fu_cnt8", count_out, 8);
    alloc(0, 0, 0, 0);
    bus.issue_ready_in = 1'b1;
    #1;
    chk("fu_ok0", bus.alloc_ok_out, 0);
    chk("fu_iaddr", bus.issue_addr_out, 0);
    step();
    bus.issue_ready_in = 1'b0;
    alloc(0, 0, 0, 0);
    #1;
    chk("fu_cnt7", count_out, 7);
    chk("fu_nfull", full_out, 0);
    chk("fu_ok1", bus.alloc_ok_out, 1);
    chk("fu_aaddr", bus.alloc_addr_out, 0);
    step();
    #1;
    chk("fu_cnt8b", count_out, 8);
    chk("fu_full2", full_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
